grayscale_word_packer: RTL
==========================

Name: grayscale_word_packer

Overview:
- Downstream stage of the RGB565-to-grayscale converter in the camera path.
- Collects 8-bit grayscale pixels, packs four per 32-bit word, and buffers the words in a small synchronous FIFO.
- The DMA/bus master drains the FIFO through a valid/ready interface.
- The pixel source cannot stall; words that arrive when the FIFO is full are dropped and flagged.

Parameters:
- FIFO_ADDR_BITS, 4, log2 of FIFO depth (depth = 2**FIFO_ADDR_BITS words, 16 by default).

Ports:
- clock  input  1  system clock, all logic on rising edge
- nReset  input  1  asynchronous active-low reset
- clearFifo  input  1  synchronous clear; empties FIFO, resets packer, clears overflow
- pixelValid  input  1  grayscale byte valid this cycle
- grayscale  input  8  grayscale pixel from converter
- lastPixel  input  1  qualifies pixelValid; marks final pixel of frame, forces flush of partial word
- wordValid  output  1  FIFO non-empty
- wordData  output  32  head-of-FIFO word (first-word-fall-through)
- wordLast  output  1  head word contains the frame's last pixel
- wordReady  input  1  consumer accepts head word when wordValid=1
- fillLevel  output  FIFO_ADDR_BITS+1  number of words stored, 0..depth
- overflow  output  1  sticky; a word was dropped because FIFO was full

Behaviour:
- Reset (nReset=0, asynchronous): packer count=0, shift register=0, FIFO empty, wordValid=0, wordLast=0, fillLevel=0, overflow=0.
- wordData is don't-care when wordValid=0.
- Packing:
  - 2-bit count k. On pixelValid, byte goes to bits [8k+7:8k]; first pixel of a word lands in [7:0] (little-endian byte order).
  - The word completes when k=3, or on any pixelValid with lastPixel=1.
  - On a lastPixel flush, unfilled upper bytes are 0x00; wordLast=1 is stored with the word.
  - Count returns to 0 after each completed word.
- Push timing: the completed word is written at the same edge that samples the completing pixel. wordValid and fillLevel reflect it in the following cycle (1-cycle latency from last byte to visible word).
- Pop: occurs at an edge where wordValid=1 and wordReady=1. wordReady with wordValid=0 is ignored.
- Simultaneous push and pop:
  - fillLevel is unchanged.
  - When the FIFO is full, the push is accepted because the pop frees a slot.
  - When the FIFO is empty, there is no pop; only the push takes effect.
- Full without a pop: the completed word is discarded and overflow is set (sticky). The packer still resets its count, so the next pixel starts a new word.
- Pointers: read and write pointers of FIFO_ADDR_BITS wrap modulo depth. Full/empty is derived from fillLevel.
- clearFifo has priority over push, pop and overflow set in the same cycle. After the edge: FIFO empty, count=0, overflow=0, and any pixel presented in that cycle is discarded.
- A reset mid-word discards the partial word; no flush occurs.
- Arithmetic: fillLevel is updated by +1, -1 or 0 only, and never exceeds depth or underflows.

Test Plan:
- After reset, 4 pixels 0x11,0x22,0x33,0x44 on consecutive cycles with wordReady=0 -> the cycle after the 4th: wordValid=1, wordData=0x44332211, wordLast=0, fillLevel=1.
- Pixels 0xAA,0xBB with lastPixel=1 on the second -> wordData=0x0000BBAA, wordLast=1. The next 4 pixels form a fresh word starting at byte 0.
- Push 16 words with wordReady=0, then one more word -> fillLevel stays 16, overflow=1, and draining yields exactly the first 16 words in order.
- FIFO full, and a completing pixel arrives in the same cycle as wordReady=1 -> the word is accepted, fillLevel stays 16, overflow stays 0.
- 40 words streamed with wordReady toggling every cycle -> every word is received in order and intact across pointer wrap; fillLevel returns to 0 at the end.
- Two pixels buffered and 3 words queued, then clearFifo=1 together with pixelValid -> the next cycle shows wordValid=0, fillLevel=0, overflow=0, and the following 4 pixels produce one correct word.

Source files
------------

// File: rtl/grayscale_word_packer.sv
// grayscale_word_packer
//   Packs 8-bit grayscale pixels four per 32-bit word (first pixel in bits
//   [7:0]) and queues the words in a first-word-fall-through FIFO that a bus
//   master drains over valid/ready. The pixel source cannot be stalled, so a
//   word that completes while the FIFO is full is dropped and a sticky
//   overflow flag is raised.
//
// Ports
//   clock       system clock, rising edge
//   nReset      asynchronous active-low reset
//   clearFifo   synchronous clear of FIFO, packer and overflow flag
//   pixelValid  grayscale byte valid this cycle
//   grayscale   8-bit pixel
//   lastPixel   with pixelValid: final pixel of the frame, flushes partial word
//   wordValid   FIFO holds at least one word
//   wordData    head word (valid only while wordValid=1)
//   wordLast    head word carries the frame's last pixel
//   wordReady   consumer takes the head word when wordValid=1
//   fillLevel   number of stored words, 0..2**FIFO_ADDR_BITS
//   overflow    sticky: a completed word was dropped
module grayscale_word_packer #(
    parameter int FIFO_ADDR_BITS = 4
) (
    input  logic                      clock,
    input  logic                      nReset,
    input  logic                      clearFifo,
    input  logic                      pixelValid,
    input  logic [7:0]                grayscale,
    input  logic                      lastPixel,
    output logic                      wordValid,
    output logic [31:0]               wordData,
    output logic                      wordLast,
    input  logic                      wordReady,
    output logic [FIFO_ADDR_BITS:0]   fillLevel,
    output logic                      overflow
);

    localparam int                      DEPTH      = 1 << FIFO_ADDR_BITS;
    localparam logic [FIFO_ADDR_BITS:0] FULL_LEVEL = (FIFO_ADDR_BITS + 1)'(DEPTH);
    localparam logic [FIFO_ADDR_BITS:0] LEVEL_ONE  = (FIFO_ADDR_BITS + 1)'(1);
    localparam logic [FIFO_ADDR_BITS-1:0] PTR_ONE  = FIFO_ADDR_BITS'(1);

    logic [1:0]                count;
    logic [31:0]               pack_reg;
    logic [32:0]               mem [DEPTH];
    logic [FIFO_ADDR_BITS-1:0] rd_ptr;
    logic [FIFO_ADDR_BITS-1:0] wr_ptr;
    logic [FIFO_ADDR_BITS:0]   level;
    logic                      ovf;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      pop;
    logic                      word_done;
    logic                      push;
    logic                      drop;
    logic [31:0]               next_word;

    // Drop a byte into its lane of the partial word. The partial register is
    // cleared after every completed word, so lanes above the current one are
    // already zero and a lastPixel flush needs no extra masking.
    function automatic logic [31:0] insert_byte(input logic [31:0] partial,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  pixel);
        logic [31:0] w;
        w = partial;
        w[{lane, 3'b000} +: 8] = pixel;
        return w;
    endfunction

    always_comb begin
        fifo_full  = (level == FULL_LEVEL);
        fifo_empty = (level == '0);
        pop        = !fifo_empty && wordReady;
        word_done  = pixelValid && ((count == 2'd3) || lastPixel);
        // A pop in the same cycle frees the slot a full FIFO needs.
        push       = word_done && (!fifo_full || pop);
        drop       = word_done && fifo_full && !pop;
        next_word  = insert_byte(pack_reg, count, grayscale);
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            count    <= 2'd0;
            pack_reg <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            ovf      <= 1'b0;
        end else if (clearFifo) begin
            count    <= 2'd0;
            pack_reg <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            ovf      <= 1'b0;
        end else begin
            if (pixelValid) begin
                // The packer restarts even when the completed word is dropped.
                if (word_done) begin
                    count    <= 2'd0;
                    pack_reg <= '0;
                end else begin
                    count    <= count + 2'd1;
                    pack_reg <= next_word;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage carries no reset; only the pointers and level decide validity.
    always_ff @(posedge clock) begin
        if (push && !clearFifo) begin
            mem[wr_ptr] <= {lastPixel, next_word};
        end
    end

    assign wordValid = !fifo_empty;
    assign wordData  = mem[rd_ptr][31:0];
    assign wordLast  = !fifo_empty && mem[rd_ptr][32];
    assign fillLevel = level;
    assign overflow  = ovf;

endmodule
